serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Processes DIGIT bits per clock, MSB first, through a small FSM.
- Supports unsigned and two's-complement modes, selected per operation.
- Uses a start/busy/done handshake and holds registered g/l/e flags until the next result. Used where a wide parallel compare would break timing or area budgets.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 1.
- DIGIT, 2, bits examined per compare cycle; must be at least 1 and divide WIDTH exactly. Elaboration fails otherwise.
- K (derived, localparam) = WIDTH/DIGIT, the number of compare cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when idle
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
- x  input  WIDTH  operand A; captured with start
- y  input  WIDTH  operand B; captured with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when g/l/e are updated
- g  output  1  x > y for the last completed operation
- l  output  1  x < y for the last completed operation
- e  output  1  x == y for the last completed operation

Behaviour:
- Reset: on a clk edge with rst=1, busy, done, g, l and e all go to 0, the FSM goes to IDLE and captured operands are discarded. rst has priority over every other input. Reset mid-compare aborts silently; no done pulse follows.
- FSM states are IDLE and CMP.
- IDLE:
  - If start=1 at an edge (edge T0), capture x, y and signed_mode, clear the digit index and the resolved flag, set busy=1, and go to CMP.
  - If start=0, stay in IDLE.
  - done is 0 at every IDLE edge without completion.
- Signed handling: in signed mode, invert bit WIDTH-1 of both captured operands (offset binary). All later compare logic is unsigned.
- CMP:
  - Each edge compares the next DIGIT-bit slice, starting at the MSB slice.
  - While the resolved flag is 0 and the slices differ, latch the direction (gt or lt) and set resolved=1.
  - Once resolved=1, later slices never change the decision.
- Completion occurs at edge TK (K edges after T0) when early exit is disabled. At that edge:
  - g, l and e load the decision; e=1 if nothing was resolved.
  - done=1 for exactly one cycle.
  - busy=0 and the FSM returns to IDLE.
- g, l and e are one-hot after the first completion and all 0 before it. They hold until the next completion or reset.
- start while busy=1 is ignored; it is neither queued nor does it alter captured operands. x, y and signed_mode may change freely after T0.
- Back-to-back operation: start=1 in the cycle where done=1 (FSM already in IDLE) is accepted. Throughput is one result per K+1 cycles, or fewer cycles with early exit.
- Edge cases:
  - DIGIT=WIDTH gives K=1, a single compare edge.
  - WIDTH=1 is legal in signed mode: x=1 is read as -1.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: completion happens on the same edge that first resolves a difference. With the first differing slice at index i (0 = MSB slice), done pulses at edge T(i+1). Equal operands still take K edges.
- Undefined: latency is always exactly K edges, independent of the data, which gives constant timing.
- Both builds produce identical g/l/e values for the same inputs.

Test Plan:
1. Defaults, unsigned: x=0xA5, y=0x5A, start pulse -> busy high for 4 cycles; done pulses 4 cycles after the start edge with g=1, l=0, e=0.
2. signed_mode=1, x=0xFF, y=0x01 -> l=1 (-1 < 1). Repeat with signed_mode=0 -> g=1. Also check x=0x80, y=0x7F signed -> l=1.
3. x=y=0x3C in both builds -> e=1 with done exactly 4 cycles after start. Then x=0x00, y=0xFF unsigned -> l=1, and e clears.
4. SERIAL_CMP_EARLY_EXIT_EN defined: x=0x80, y=0x00 -> done 1 cycle after start, g=1. x=0x01, y=0x00 -> done after 4 cycles, g=1. Without the macro, both take 4 cycles.
5. start held high continuously, operands changed every cycle -> only the values captured at each accepted edge are compared. Starts during busy are ignored, and a new compare begins on each done cycle (period 5).
6. Assert rst for one cycle during the 2nd compare cycle -> on the next edge busy=done=g=l=e=0 and no done pulse follows. A subsequent start completes normally.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's-complement.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing slice.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int K     = WIDTH / DIGIT;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_magnitude_comparator: WIDTH must be >= 1 and an exact multiple of DIGIT >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx_q;
  logic             resolved_q;
  logic             gt_q;

  logic [DIGIT-1:0] slice_a_d;
  logic [DIGIT-1:0] slice_b_d;
  logic             slice_ne_d;
  logic             resolved_d;
  logic             gt_d;
  logic             finish_d;

  // Offset-binary mapping: flipping the sign bit turns a signed order into an unsigned one.
  function automatic logic [WIDTH-1:0] map_operand(input logic [WIDTH-1:0] v, input logic s);
    logic [WIDTH-1:0] r;
    r            = v;
    r[WIDTH-1]   = v[WIDTH-1] ^ s;
    return r;
  endfunction

  // Compare the current MSB-aligned slice and fold it into the running decision.
  always_comb begin
    slice_a_d  = a_q[WIDTH-1 -: DIGIT];
    slice_b_d  = b_q[WIDTH-1 -: DIGIT];
    slice_ne_d = (slice_a_d != slice_b_d);
    resolved_d = resolved_q | slice_ne_d;
    if (resolved_q) begin
      gt_d = gt_q;
    end else begin
      gt_d = (slice_a_d > slice_b_d);
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (idx_q == LAST_IDX) begin
      finish_d = 1'b1;
    end else if (!resolved_q && slice_ne_d) begin
      finish_d = 1'b1;
    end else begin
      finish_d = 1'b0;
    end
`else
    if (idx_q == LAST_IDX) begin
      finish_d = 1'b1;
    end else begin
      finish_d = 1'b0;
    end
`endif
  end

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      g          <= 1'b0;
      l          <= 1'b0;
      e          <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      resolved_q <= 1'b0;
      gt_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= map_operand(x, signed_mode);
            b_q        <= map_operand(y, signed_mode);
            idx_q      <= '0;
            resolved_q <= 1'b0;
            gt_q       <= 1'b0;
            busy       <= 1'b1;
            state_q    <= CMP;
          end else begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        CMP: begin
          if (finish_d) begin
            g       <= resolved_d & gt_d;
            l       <= resolved_d & ~gt_d;
            e       <= ~resolved_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Shift the next slice into the MSB window instead of muxing by index.
            a_q        <= a_q << DIGIT;
            b_q        <= b_q << DIGIT;
            idx_q      <= idx_q + IDX_W'(1);
            resolved_q <= resolved_d;
            gt_q       <= gt_d;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2, K=4).
// Expected latency follows SERIAL_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_serial_magnitude_comparator;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int K = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic       g;
  logic       l;
  logic       e;

  int n_checks = 0;
  int n_pass   = 0;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .g           (g),
    .l           (l),
    .e           (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_res: 0 = equal, 1 = x>y, 2 = x<y; diff_slice: first differing slice (-1 if none).
  task automatic run_cmp(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                         input logic s, input int exp_res, input int diff_slice);
    int  exp_lat;
    int  lat;
    bit  seen;
    bit  busy_ok;
    exp_lat = (EARLY && diff_slice >= 0) ? diff_slice + 1 : K;
    x = xa; y = ya; signed_mode = s; start = 1'b1;
    tick();
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); signed_mode = 1'($urandom);
    check_eq({tag, "_busy_t0"}, {31'd0, busy}, 32'd1);
    seen = 1'b0; lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      if (!seen) begin
        tick();
        if (done) begin
          seen = 1'b1;
          lat  = n;
        end else if (!busy) begin
          busy_ok = 1'b0;
        end
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_g"}, {31'd0, g}, (exp_res == 1) ? 32'd1 : 32'd0);
    check_eq({tag, "_l"}, {31'd0, l}, (exp_res == 2) ? 32'd1 : 32'd0);
    check_eq({tag, "_e"}, {31'd0, e}, (exp_res == 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    tick();
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit no_done;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; x = 8'h00; y = 8'h00;
    repeat (3) tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_gle", {29'd0, g, l, e}, 32'd0);
    rst = 1'b0;
    tick();

    run_cmp("a5_5a_u",  8'hA5, 8'h5A, 1'b0, 1, 0);
    run_cmp("ff_01_s",  8'hFF, 8'h01, 1'b1, 2, 0);
    run_cmp("ff_01_u",  8'hFF, 8'h01, 1'b0, 1, 0);
    run_cmp("80_7f_s",  8'h80, 8'h7F, 1'b1, 2, 0);
    run_cmp("7f_80_s",  8'h7F, 8'h80, 1'b1, 1, 0);
    run_cmp("3c_3c_u",  8'h3C, 8'h3C, 1'b0, 0, -1);
    run_cmp("3c_3c_s",  8'h3C, 8'h3C, 1'b1, 0, -1);
    run_cmp("00_ff_u",  8'h00, 8'hFF, 1'b0, 2, 0);
    run_cmp("80_00_u",  8'h80, 8'h00, 1'b0, 1, 0);
    run_cmp("01_00_u",  8'h01, 8'h00, 1'b0, 1, 3);
    run_cmp("24_28_u",  8'h24, 8'h28, 1'b0, 2, 2);
    run_cmp("27_18_u",  8'h27, 8'h18, 1'b0, 1, 1);

    // start held high, operands changing every cycle; only differences in the last slice.
    for (int c = 0; c < 20; c++) begin
      logic [5:0] hi;
      hi    = 6'(c);
      start = 1'b1;
      signed_mode = 1'b0;
      if ((c % 2) == 0) begin
        x = {hi, 2'b01}; y = {hi, 2'b10};
      end else begin
        x = {hi, 2'b11}; y = {hi, 2'b00};
      end
      tick();
      check_eq($sformatf("b2b_done_c%0d", c), {31'd0, done}, ((c % 5) == 4) ? 32'd1 : 32'd0);
      if ((c % 5) == 4) begin
        check_eq($sformatf("b2b_g_c%0d", c), {31'd0, g}, (((c / 5) % 2) == 1) ? 32'd1 : 32'd0);
        check_eq($sformatf("b2b_l_c%0d", c), {31'd0, l}, (((c / 5) % 2) == 0) ? 32'd1 : 32'd0);
      end
    end
    start = 1'b0;
    tick();

    // Reset during the second compare cycle aborts the operation silently.
    x = 8'hA5; y = 8'h5A; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_gle", {29'd0, g, l, e}, 32'd0);
    no_done = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done || busy) no_done = 1'b0;
    end
    check_eq("abort_quiet", {31'd0, no_done}, 32'd1);
    run_cmp("after_rst", 8'h10, 8'h20, 1'b0, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
